// File: rtl/debug_uart_bridge.sv
// debug_uart_bridge: UART (8N1) command front end for the core's 8-bit debug port.
// Host sends a command byte (bit7 = write, bits[2:0] = register), plus one data
// byte for writes. Reads return DEBUG_DOUT as one UART byte.
module debug_uart_bridge #(
  parameter int CLK_DIV = 434
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UART_RXD,
  output logic       UART_TXD,
  output logic [7:0] DEBUG_DIN,
  input  logic [7:0] DEBUG_DOUT,
  output logic [2:0] DEBUG_REG_ADDR,
  output logic       DEBUG_WRN,
  output logic       DEBUG_RDN,
  output logic       BRIDGE_BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    IDLE, WAIT_DATA, WR_SETUP, WR_STROBE, WR_HOLD,
    RD_SETUP, RD_STROBE1, RD_STROBE2, TX_WAIT
  } state_t;

  logic        rxd_meta_r, rxd_sync_r, rxd_prev_r;
  rx_state_t   rx_state_r, rx_state_n;
  logic [15:0] rx_cnt_r, rx_cnt_n;
  logic [2:0]  rx_bit_r, rx_bit_n;
  logic [7:0]  rx_shift_r, rx_shift_n;
  logic        rx_done_s;
  logic        hold_valid_r, consume_s, hold_full_s;
  logic [7:0]  hold_data_r;
  logic        frame_err_r, overrun_r;
  state_t      state_r, state_n;
  logic [2:0]  addr_r;
  logic [7:0]  din_r, rd_data_r;
  logic        wrn_r, rdn_r, tx_pend_r;
  logic        latch_addr_s, latch_din_s, capture_s;
  logic        tx_start_s, tx_ready_s;
  logic [7:0]  tx_data_s;
  logic        tx_busy_r, txd_r;
  logic [15:0] tx_cnt_r;
  logic [3:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= UART_RXD;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // RX sequencer next state: start check at half bit, then full-bit spacing
  always_comb begin
    rx_state_n = rx_state_r;
    rx_cnt_n   = rx_cnt_r + 16'd1;
    rx_bit_n   = rx_bit_r;
    rx_shift_n = rx_shift_r;
    rx_done_s  = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_n = 16'd0;
        if (rxd_prev_r && !rxd_sync_r) rx_state_n = RX_START;
        else                           rx_state_n = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_LAST) begin
          rx_cnt_n = 16'd0;
          rx_bit_n = 3'd0;
          // A high start sample is a glitch: drop silently
          if (rxd_sync_r) rx_state_n = RX_IDLE;
          else            rx_state_n = RX_DATA;
        end else begin
          rx_state_n = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == DIV_LAST) begin
          rx_cnt_n   = 16'd0;
          rx_shift_n = {rxd_sync_r, rx_shift_r[7:1]};
          rx_bit_n   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_n = RX_STOP;
          else                  rx_state_n = RX_DATA;
        end else begin
          rx_state_n = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == DIV_LAST) begin
          rx_cnt_n   = 16'd0;
          rx_done_s  = 1'b1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_STOP;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX sequencer registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_state_r <= rx_state_n;
      rx_cnt_r   <= rx_cnt_n;
      rx_bit_r   <= rx_bit_n;
      rx_shift_r <= rx_shift_n;
    end
  end

  assign consume_s   = hold_valid_r && ((state_r == IDLE) || (state_r == WAIT_DATA));
  assign hold_full_s = hold_valid_r && !consume_s;

  // Holding register and the one-cycle error pulses raised at stop-sample time
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= 8'h00;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_err_r <= rx_done_s && !rxd_sync_r;
      overrun_r   <= rx_done_s && rxd_sync_r && hold_full_s;
      if (rx_done_s && rxd_sync_r && !hold_full_s) begin
        hold_valid_r <= 1'b1;
        hold_data_r  <= rx_shift_r;
      end else if (consume_s) begin
        hold_valid_r <= 1'b0;
      end
    end
  end

  // TX can accept a byte when idle or on the last cycle of a stop bit
  assign tx_ready_s = !tx_busy_r || ((tx_bit_r == 4'd9) && (tx_cnt_r == DIV_LAST));

  // Parser next state and handshake decode
  always_comb begin
    state_n      = state_r;
    latch_addr_s = 1'b0;
    latch_din_s  = 1'b0;
    capture_s    = 1'b0;
    tx_start_s   = 1'b0;
    tx_data_s    = rd_data_r;
    case (state_r)
      IDLE: begin
        if (hold_valid_r) begin
          latch_addr_s = 1'b1;
          if (hold_data_r[7]) state_n = WAIT_DATA;
          else                state_n = RD_SETUP;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_DATA: begin
        if (frame_err_r) begin
          state_n = IDLE;
        end else if (hold_valid_r) begin
          latch_din_s = 1'b1;
          state_n     = WR_SETUP;
        end else begin
          state_n = WAIT_DATA;
        end
      end
      WR_SETUP:   state_n = WR_STROBE;
      WR_STROBE:  state_n = WR_HOLD;
      WR_HOLD:    state_n = IDLE;
      RD_SETUP:   state_n = RD_STROBE1;
      RD_STROBE1: state_n = RD_STROBE2;
      RD_STROBE2: begin
        // Hand DOUT straight to an idle transmitter so the start bit follows at once
        capture_s = 1'b1;
        state_n   = TX_WAIT;
        if (tx_ready_s) begin
          tx_start_s = 1'b1;
          tx_data_s  = DEBUG_DOUT;
        end else begin
          tx_start_s = 1'b0;
        end
      end
      TX_WAIT: begin
        if (!tx_pend_r) begin
          state_n = IDLE;
        end else if (tx_ready_s) begin
          tx_start_s = 1'b1;
          state_n    = IDLE;
        end else begin
          state_n = TX_WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Parser registers; strobes are registered from the next state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= IDLE;
      addr_r    <= 3'd0;
      din_r     <= 8'h00;
      rd_data_r <= 8'h00;
      tx_pend_r <= 1'b0;
      wrn_r     <= 1'b1;
      rdn_r     <= 1'b1;
    end else begin
      state_r <= state_n;
      if (latch_addr_s) addr_r    <= hold_data_r[2:0];
      if (latch_din_s)  din_r     <= hold_data_r;
      if (capture_s) begin
        rd_data_r <= DEBUG_DOUT;
        tx_pend_r <= !tx_start_s;
      end else if (tx_start_s) begin
        tx_pend_r <= 1'b0;
      end
      wrn_r <= (state_n != WR_STROBE);
      rdn_r <= (state_n != RD_STROBE1) && (state_n != RD_STROBE2);
    end
  end

  // Transmitter: start, 8 data LSB first, stop; each bit CLK_DIV cycles
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_busy_r  <= 1'b0;
      txd_r      <= 1'b1;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= 8'h00;
    end else if (tx_start_s) begin
      tx_busy_r  <= 1'b1;
      txd_r      <= 1'b0;
      tx_cnt_r   <= 16'd0;
      tx_bit_r   <= 4'd0;
      tx_shift_r <= tx_data_s;
    end else if (tx_busy_r) begin
      if (tx_cnt_r == DIV_LAST) begin
        tx_cnt_r <= 16'd0;
        if (tx_bit_r == 4'd9) begin
          tx_busy_r <= 1'b0;
          txd_r     <= 1'b1;
        end else begin
          tx_bit_r <= tx_bit_r + 4'd1;
          txd_r    <= (tx_bit_r < 4'd8) ? tx_shift_r[tx_bit_r[2:0]] : 1'b1;
        end
      end else begin
        tx_cnt_r <= tx_cnt_r + 16'd1;
      end
    end
  end

  assign UART_TXD       = txd_r;
  assign DEBUG_DIN      = din_r;
  assign DEBUG_REG_ADDR = addr_r;
  assign DEBUG_WRN      = wrn_r;
  assign DEBUG_RDN      = rdn_r;
  assign FRAME_ERR      = frame_err_r;
  assign OVERRUN        = overrun_r;
  assign BRIDGE_BUSY    = (state_r != IDLE) || tx_busy_r;

endmodule
